// File: rtl/cist_programmer.sv
`default_nettype none
// ============================================================================
//  Module   : cist_programmer
//  Brief    : Framed byte-stream loader for the custom-instruction status
//             table entries (cistC1/cistC2). New entries commit only once the
//             custom pipe is drained.
//  Revision : 1.0  initial release
// ============================================================================
module cist_programmer #(
    parameter logic [5:0] C1_RESET      = 6'b110010,
    parameter logic [5:0] C2_RESET      = 6'b111000,
    parameter logic [7:0] HDR_BYTE      = 8'hA5,
    parameter int         DRAIN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       pipe_idle,
    output logic       hold_custom,
    output logic [5:0] cistC1,
    output logic [5:0] cistC2,
    output logic       commit,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int                CNT_W    = $clog2(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DRAIN  = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sel_q, sel_d;
    logic [7:0]         data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         c1_q, c1_d;
    logic [5:0]         c2_q, c2_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               w_accept;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        cfg_ready   = (state_q != S_DRAIN) && (state_q != S_COMMIT);
        hold_custom = (state_q == S_DRAIN) || (state_q == S_COMMIT);
        commit      = (state_q == S_COMMIT);
        w_accept    = cfg_valid && cfg_ready;

        case (state_q)
            S_IDLE: begin
                if (w_accept && (cfg_data == HDR_BYTE)) state_d = S_SEL;
            end
            S_SEL: begin
                if (w_accept) begin
                    sel_d   = cfg_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    data_d  = cfg_data;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    // Checks are prioritised: select, reserved bits, checksum.
                    state_d = S_IDLE;
                    if ((sel_q != 8'h01) && (sel_q != 8'h02)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd0;
                    end else if (data_q[7:6] != 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else if (cfg_data != (sel_q ^ data_q)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                // pipe_idle is tested first so it wins against the timeout.
                if (pipe_idle) begin
                    state_d = S_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                if (sel_q == 8'h01) c1_d = data_q[5:0];
                else                c2_d = data_q[5:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            c1_q       <= C1_RESET;
            c2_q       <= C2_RESET;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cistC1   = c1_q;
    assign cistC2   = c2_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_cist_programmer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cist_programmer
//  Brief    : Scoreboard bench for cist_programmer; commit/err events are
//             predicted into a queue and checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cist_programmer;

    localparam logic [5:0] C1_RST = 6'h32;
    localparam logic [5:0] C2_RST = 6'h38;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       pipe_idle;
    logic       hold_custom;
    logic [5:0] cistC1, cistC2;
    logic       commit, err;
    logic [1:0] err_code;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        logic [5:0] c1;
        logic [5:0] c2;
    } ev_t;

    ev_t        exp_q[$];
    logic [5:0] m_c1 = C1_RST;
    logic [5:0] m_c2 = C2_RST;

    cist_programmer #(
        .C1_RESET(6'b110010), .C2_RESET(6'b111000),
        .HDR_BYTE(8'hA5), .DRAIN_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .pipe_idle(pipe_idle), .hold_custom(hold_custom),
        .cistC1(cistC1), .cistC2(cistC2), .commit(commit), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one prediction per commit/err pulse; entries checked next cycle.
    logic       pend = 1'b0;
    logic [5:0] pend_c1, pend_c2;
    always @(negedge clk) begin
        ev_t e;
        if (pend) begin
            chk("sb_cistC1", cistC1, pend_c1);
            chk("sb_cistC2", cistC2, pend_c2);
            pend = 1'b0;
        end
        if (!reset && (commit || err)) begin
            chk("sb_not_both", commit & err, 1'b0);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_event", {commit, err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("sb_kind_err", err, e.is_err);
                if (e.is_err) chk("sb_err_code", err_code, e.code);
                pend    = 1'b1;
                pend_c1 = e.c1;
                pend_c2 = e.c2;
            end
        end
    end

    task automatic push_commit(input logic [7:0] sel, input logic [7:0] data);
        ev_t e;
        if (sel == 8'h01) m_c1 = data[5:0];
        else              m_c2 = data[5:0];
        e.is_err = 1'b0; e.code = 2'd0; e.c1 = m_c1; e.c2 = m_c2;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        ev_t e;
        e.is_err = 1'b1; e.code = code; e.c1 = m_c1; e.c2 = m_c2;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b1;
        cfg_data  = b;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] sel, input logic [7:0] data, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(sel);
        send_byte(data);
        send_byte(cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hold_cnt;
        reset = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00; pipe_idle = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cistC1", cistC1, C1_RST);
        chk("rst_cistC2", cistC2, C2_RST);
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_hold", hold_custom, 1'b0);
        chk("rst_commit", commit, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        reset = 1'b0;

        // Basic C1 load with an idle pipe: DRAIN one cycle, then COMMIT.
        push_commit(8'h01, 8'h2C);
        send_frame(8'h01, 8'h2C, 8'h2D);
        @(negedge clk);
        chk("t1_drain_ready", cfg_ready, 1'b0);
        chk("t1_drain_hold", hold_custom, 1'b1);
        chk("t1_drain_commit", commit, 1'b0);
        @(negedge clk);
        chk("t1_commit_ready", cfg_ready, 1'b0);
        chk("t1_commit_hold", hold_custom, 1'b1);
        chk("t1_commit_pulse", commit, 1'b1);
        @(negedge clk);
        chk("t1_idle_ready", cfg_ready, 1'b1);
        chk("t1_idle_hold", hold_custom, 1'b0);
        chk("t1_cistC1", cistC1, 6'h2C);
        chk("t1_cistC2", cistC2, C2_RST);

        // Checksum error, then a good C2 frame.
        push_err(2'd2);
        send_frame(8'h02, 8'h30, 8'h33);
        @(negedge clk);
        chk("t2_err", err, 1'b1);
        chk("t2_err_code", err_code, 2'd2);
        chk("t2_hold", hold_custom, 1'b0);
        push_commit(8'h02, 8'h30);
        send_frame(8'h02, 8'h30, 8'h32);

        // Bad select, then reserved data bits.
        push_err(2'd0);
        send_frame(8'h03, 8'h10, 8'h13);
        push_err(2'd1);
        send_frame(8'h01, 8'hC0, 8'hC1);

        // Pipe busy for 10 DRAIN cycles.
        pipe_idle = 1'b0;
        push_commit(8'h01, 8'h15);
        send_frame(8'h01, 8'h15, 8'h14);
        hold_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hold_custom && !cfg_ready && !commit) hold_cnt++;
        end
        chk("t4_hold_cycles", hold_cnt, 10);
        pipe_idle = 1'b1;
        @(negedge clk);
        chk("t4_commit_after_idle", commit, 1'b1);
        @(negedge clk);
        chk("t4_back_idle_ready", cfg_ready, 1'b1);

        // Drain timeout: 64 DRAIN cycles, then err code 3 in IDLE.
        pipe_idle = 1'b0;
        push_err(2'd3);
        send_frame(8'h02, 8'h05, 8'h07);
        hold_cnt = 0;
        @(negedge clk);
        while (hold_custom && hold_cnt < 200) begin
            hold_cnt++;
            @(negedge clk);
        end
        chk("t5_drain_cycles", hold_cnt, 64);
        chk("t5_err", err, 1'b1);
        chk("t5_hold_dropped", hold_custom, 1'b0);

        // pipe_idle rises on the final count: commit wins.
        push_commit(8'h01, 8'h09);
        send_frame(8'h01, 8'h09, 8'h08);
        repeat (64) @(negedge clk);
        chk("t5b_still_hold", hold_custom, 1'b1);
        pipe_idle = 1'b1;
        @(negedge clk);
        chk("t5b_commit", commit, 1'b1);
        chk("t5b_no_err", err, 1'b0);

        // Garbage before header, then reset in the middle of DRAIN.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        push_commit(8'h01, 8'h02);
        send_frame(8'h01, 8'h02, 8'h03);
        repeat (3) @(negedge clk);
        chk("t6_cistC1", cistC1, 6'h02);
        pipe_idle = 1'b0;
        send_frame(8'h02, 8'h11, 8'h13);
        @(negedge clk);
        chk("t6_in_drain", hold_custom, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_c1 = C1_RST;
        m_c2 = C2_RST;
        chk("t6_rst_cistC1", cistC1, C1_RST);
        chk("t6_rst_cistC2", cistC2, C2_RST);
        chk("t6_rst_hold", hold_custom, 1'b0);
        chk("t6_rst_ready", cfg_ready, 1'b1);
        pipe_idle = 1'b1;
        push_commit(8'h02, 8'h11);
        send_frame(8'h02, 8'h11, 8'h13);
        repeat (4) @(negedge clk);
        chk("t6_post_rst_cistC2", cistC2, 6'h11);

        repeat (3) @(negedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
